// File: rtl/load_pkg.sv
// load_pkg: shared types, beat counts and alignment rule for load_sequencer
package load_pkg;
    typedef enum logic [1:0] {BYTE, HALF, WORD, ILLEGAL} load_size_t;
    typedef enum logic [1:0] {IDLE, READ, DONE} load_state_t;
    localparam logic [2:0] BEATS_BYTE = 3'd1;
    localparam logic [2:0] BEATS_HALF = 3'd2;
    localparam logic [2:0] BEATS_WORD = 3'd4;
    function automatic logic [2:0] beats(input load_size_t s);
        return s == BYTE ? BEATS_BYTE : s == HALF ? BEATS_HALF : BEATS_WORD;
    endfunction
    function automatic logic misaligned(input load_size_t s, input logic [1:0] a);
        return s == ILLEGAL || (s == HALF && a[0]) || (s == WORD && a != 2'b00);
    endfunction
endpackage

// File: rtl/SignExtender.sv
// SignExtender: widens narrow to wide, filling with the top bit when signExtend is set, else zeros
//   narrow     in  INPUT_WIDTH  value to widen
//   signExtend in  1            1 = replicate narrow MSB, 0 = zero fill
//   wide       out OUTPUT_WIDTH widened value
module SignExtender #(
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic [INPUT_WIDTH-1:0]  narrow,
    input  logic                    signExtend,
    output logic [OUTPUT_WIDTH-1:0] wide
);
    assign wide = {{(OUTPUT_WIDTH-INPUT_WIDTH){signExtend & narrow[INPUT_WIDTH-1]}}, narrow};
endmodule

// File: rtl/load_sequencer.sv
// load_sequencer: turns one load request into big-endian byte beats and returns the extended result
//   clk, reset                       clock, synchronous active-high reset
//   reqValid/reqReady/reqAddr/reqSize/reqSigned   request from the memory stage
//   memReq/memAddr/memData/memAck    byte-wide bus, one beat per memAck
//   respValid/respReady/respData/respError        registered result, held until taken
module load_sequencer
    import load_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [1:0]            reqSize,
    input  logic                  reqSigned,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [7:0]            memData,
    input  logic                  memAck,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [DATA_WIDTH-1:0] respData,
    output logic                  respError
);
    load_state_t           state, nxt;
    load_size_t            size, rsize;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sgn, bad, last;
    logic [2:0]            beat;
    logic [DATA_WIDTH-1:0] asm_q, asm_nxt, ext8, ext16, ext;

    assign rsize   = load_size_t'(reqSize);
    assign bad     = misaligned(rsize, reqAddr[1:0]);
    assign last    = beat == beats(size) - 3'd1;
    // extension is taken from the value the final beat produces so respData is ready on entry to DONE
    assign asm_nxt = {asm_q[DATA_WIDTH-9:0], memData};

    SignExtender #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(DATA_WIDTH)) u_ext8 (
        .narrow(asm_nxt[7:0]), .signExtend(sgn), .wide(ext8)
    );
    SignExtender #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(DATA_WIDTH)) u_ext16 (
        .narrow(asm_nxt[15:0]), .signExtend(sgn), .wide(ext16)
    );

    assign ext       = size == BYTE ? ext8 : size == HALF ? ext16 : asm_nxt;
    assign reqReady  = state == IDLE;
    assign memReq    = state == READ;
    assign memAddr   = memReq ? addr + ADDR_WIDTH'(beat) : '0;
    assign respValid = state == DONE;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state == IDLE ? (reqValid ? (bad ? DONE : READ) : IDLE) :
              state == READ ? (memAck && last ? DONE : READ) :
              (respReady ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            size      <= BYTE;
            sgn       <= 1'b0;
            beat      <= '0;
            asm_q     <= '0;
            respData  <= '0;
            respError <= 1'b0;
        end else if (state == IDLE && reqValid) begin
            addr      <= reqAddr;
            size      <= rsize;
            sgn       <= reqSigned;
            beat      <= '0;
            asm_q     <= '0;
            respData  <= '0;
            respError <= bad;
        end else if (state == READ && memAck) begin
            asm_q <= asm_nxt;
            beat  <= beat + 3'd1;
            if (last) respData <= ext;
        end
    end
endmodule

// File: tb/tb_load_sequencer.sv
// tb_load_sequencer: directed loads checked every cycle against an arithmetic model of the load result
module tb_load_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0, reqSigned = 1'b0, respReady = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [1:0]  reqSize = '0;
    logic        reqReady, memReq, memAck, respValid, respError;
    logic [31:0] memAddr, respData;
    logic [7:0]  memData;

    int          nvec = 0, nbad = 0;
    logic [31:0] m_addr = '0, m_bytes = '0, m_data = '0;
    logic        m_err = 1'b0, m_chk = 1'b0, ackd = 1'b0;
    int          m_beat = 0, m_wait = 0, wcnt = 0, m_n = 1;

    load_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
        .reqAddr(reqAddr), .reqSize(reqSize), .reqSigned(reqSigned),
        .memReq(memReq), .memAddr(memAddr), .memData(memData), .memAck(memAck),
        .respValid(respValid), .respReady(respReady), .respData(respData), .respError(respError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] by, output logic [31:0] d, output logic e, output int n);
        longint v = 0;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        e = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        for (int i = 0; i < n; i++) v = v * 256 + longint'(by[31-8*i -: 8]);
        if (sg && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
        d = e ? 32'd0 : 32'(v);
    endfunction

    initial begin
        memAck = 1'b0;
        memData = 8'd0;
        forever begin
            @(posedge clk);
            if (ackd) begin
                m_beat++;
                wcnt = 0;
                ackd = 1'b0;
            end
            @(negedge clk);
            if (memReq && wcnt == m_wait) begin
                memAck = 1'b1;
                memData = m_bytes[31-8*m_beat -: 8];
                ackd = 1'b1;
            end else begin
                if (memReq) wcnt++;
                memAck = memReq ? 1'b0 : 1'($urandom);
                memData = 8'($urandom);
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (m_chk && !reset) begin
            if (memReq) begin
                chk("memAddr", memAddr, m_addr + 32'(m_beat));
                chk("reqReady_busy", 32'(reqReady), 32'd0);
                chk("respValid_busy", 32'(respValid), 32'd0);
            end
            if (m_err) chk("memReq_on_error", 32'(memReq), 32'd0);
            if (respValid) begin
                chk("respData", respData, m_data);
                chk("respError", 32'(respError), 32'(m_err));
                chk("reqReady_done", 32'(reqReady), 32'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic [31:0] by, input int w);
        int k = 0;
        @(negedge clk);
        while (!reqReady && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reqReady_idle", 32'(reqReady), 32'd1);
        m_addr = a;
        m_bytes = by;
        m_wait = w;
        m_beat = 0;
        wcnt = 0;
        ackd = 1'b0;
        model(a, sz, sg, by, m_data, m_err, m_n);
        reqValid = 1'b1;
        reqAddr = a;
        reqSize = sz;
        reqSigned = sg;
        @(posedge clk);
        #1;
        reqAddr = $urandom;
        reqSize = 2'($urandom);
        reqSigned = 1'($urandom);
    endtask

    task automatic finish(input int hold, input logic [31:0] lit, input logic lerr);
        int cyc = 1;
        int lat = m_err ? 1 : m_n * (m_wait + 1) + 1;
        chk("model_data", m_data, lit);
        chk("model_err", 32'(m_err), 32'(lerr));
        @(negedge clk);
        while (!respValid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("respData_lit", respData, lit);
        chk("respError_lit", 32'(respError), 32'(lerr));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_reqReady", 32'(reqReady), 32'd0);
            chk("hold_respValid", 32'(respValid), 32'd1);
        end
        respReady = 1'b1;
        reqValid = 1'b0;
        @(negedge clk);
        respReady = 1'b0;
        chk("release_respValid", 32'(respValid), 32'd0);
        chk("release_reqReady", 32'(reqReady), 32'd1);
    endtask

    task automatic run(input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic [31:0] by,
                       input int w, input int hold, input logic [31:0] lit, input logic lerr);
        issue(a, sz, sg, by, w);
        finish(hold, lit, lerr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        chk("rst_reqReady", 32'(reqReady), 32'd1);
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_respValid", 32'(respValid), 32'd0);
        chk("rst_respData", respData, 32'd0);
        chk("rst_respError", 32'(respError), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_chk = 1'b1;
        run(32'h103, 2'd0, 1'b1, 32'h80000000, 0, 0, 32'hFFFFFF80, 1'b0);
        run(32'h103, 2'd0, 1'b0, 32'h80000000, 0, 0, 32'h00000080, 1'b0);
        run(32'h200, 2'd1, 1'b1, 32'h12340000, 2, 0, 32'h00001234, 1'b0);
        run(32'h300, 2'd2, 1'b0, 32'hDEADBEEF, 0, 4, 32'hDEADBEEF, 1'b0);
        run(32'h302, 2'd2, 1'b0, 32'h11223344, 0, 2, 32'h00000000, 1'b1);
        run(32'h500, 2'd3, 1'b1, 32'h11223344, 0, 0, 32'h00000000, 1'b1);
        run(32'h201, 2'd1, 1'b0, 32'h11223344, 0, 0, 32'h00000000, 1'b1);
        run(32'h202, 2'd1, 1'b1, 32'h80010000, 1, 1, 32'hFFFF8001, 1'b0);
        run(32'h202, 2'd1, 1'b0, 32'h80010000, 0, 0, 32'h00008001, 1'b0);
        run(32'h0FF, 2'd0, 1'b0, 32'hFF000000, 1, 0, 32'h000000FF, 1'b0);
        run(32'h0FE, 2'd0, 1'b1, 32'h7F000000, 0, 0, 32'h0000007F, 1'b0);
        run(32'hFFFFFFFC, 2'd2, 1'b1, 32'h01020304, 0, 0, 32'h01020304, 1'b0);
        run(32'h604, 2'd2, 1'b1, 32'h80000001, 1, 0, 32'h80000001, 1'b0);

        issue(32'h400, 2'd2, 1'b0, 32'hCAFEF00D, 0);
        @(negedge clk);
        @(negedge clk);
        m_chk = 1'b0;
        reset = 1'b1;
        reqValid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_memReq", 32'(memReq), 32'd0);
        chk("midrst_respValid", 32'(respValid), 32'd0);
        chk("midrst_reqReady", 32'(reqReady), 32'd1);
        chk("midrst_memAddr", memAddr, 32'd0);
        chk("midrst_respData", respData, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_chk = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_memReq", 32'(memReq), 32'd0);
        chk("postrst_respValid", 32'(respValid), 32'd0);
        chk("postrst_reqReady", 32'(reqReady), 32'd1);
        run(32'h10, 2'd0, 1'b0, 32'h5A000000, 0, 0, 32'h0000005A, 1'b0);
        run(32'h12, 2'd1, 1'b0, 32'hA5C30000, 0, 0, 32'h0000A5C3, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
